// File: rtl/mod14_count_monitor_pkg.sv
// Shared types, constants and the mod-14 next-value prediction used by the
// count monitor and by anything that wants to model the counter.
package mod14_count_monitor_pkg;

    localparam logic [3:0] MOD14_MAX = 4'd13;
    localparam int         MOD14_N   = 14;

    typedef enum logic [1:0] {ERR_NONE, ERR_STEP, ERR_VALUE, ERR_LOAD} mon_err_e;
    typedef enum logic [1:0] {MON_IDLE, MON_TRACK, MON_ERROR} mon_state_e;

    function automatic logic [3:0] mod14_next(
        input logic [3:0] prev_count,
        input logic       prev_load,
        input logic       prev_up_down,
        input logic [3:0] prev_data_in
    );
        logic [3:0] nxt;
        if (prev_load) begin
            nxt = prev_data_in;
        end else if (prev_up_down) begin
            nxt = (prev_count == MOD14_MAX) ? 4'd0 : prev_count + 4'd1;
        end else begin
            nxt = (prev_count == 4'd0) ? MOD14_MAX : prev_count - 4'd1;
        end
        return nxt;
    endfunction

    function automatic logic mod14_legal(input logic [3:0] value);
        return value < 4'(MOD14_N);
    endfunction

endpackage

// File: rtl/mod14_count_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/mod14_count_monitor.sv
// Passive checker beside the mod-14 up/down counter: predicts each step from
// the previous cycle's controls, flags bad values/steps and counts legal wraps.
module mod14_count_monitor
    import mod14_count_monitor_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              up_down,
    input  logic [3:0]        data_in,
    input  logic [3:0]        count,
    input  logic              clr,
    output logic              valid,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] down_wraps,
    output logic              err,
    output logic [1:0]        err_code
);

    mon_state_e state_q, state_d;
    logic [3:0] prev_count_q, prev_data_in_q;
    logic       prev_load_q, prev_up_down_q;
    logic       valid_q, valid_d;
    logic       tc_pulse_q, tc_pulse_d;
    logic       err_q, err_d;
    mon_err_e   err_code_q, err_code_d;

    logic [3:0] expected;
    mon_err_e   code;
    logic       checking;
    logic       clean_step;
    logic       up_wrap;
    logic       down_wrap;

    // An illegal load is not step-compared; the next cycle resyncs on count.
    always_comb begin
        expected = mod14_next(prev_count_q, prev_load_q, prev_up_down_q, prev_data_in_q);
        if (!mod14_legal(count)) begin
            code = ERR_VALUE;
        end else if (prev_load_q && !mod14_legal(prev_data_in_q)) begin
            code = ERR_LOAD;
        end else if (count != expected) begin
            code = ERR_STEP;
        end else begin
            code = ERR_NONE;
        end
        checking   = (state_q != MON_IDLE);
        clean_step = checking && (code == ERR_NONE) && !prev_load_q;
        up_wrap    = clean_step && prev_up_down_q && (prev_count_q == MOD14_MAX) && (count == 4'd0);
        down_wrap  = clean_step && !prev_up_down_q && (prev_count_q == 4'd0) && (count == MOD14_MAX);
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        tc_pulse_d = up_wrap || down_wrap;
        unique case (state_q)
            MON_IDLE:  state_d = MON_TRACK;
            MON_TRACK: begin
                if (code != ERR_NONE) begin
                    state_d    = MON_ERROR;
                    err_d      = 1'b1;
                    err_code_d = code;
                end
            end
            MON_ERROR: state_d = MON_ERROR;
            default:   state_d = MON_IDLE;
        endcase
        if (clr) begin
            state_d    = MON_IDLE;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            tc_pulse_d = 1'b0;
        end
        valid_d = (state_d != MON_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= MON_IDLE;
            prev_count_q   <= 4'd0;
            prev_load_q    <= 1'b0;
            prev_up_down_q <= 1'b0;
            prev_data_in_q <= 4'd0;
            valid_q        <= 1'b0;
            tc_pulse_q     <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            prev_count_q   <= count;
            prev_load_q    <= load;
            prev_up_down_q <= up_down;
            prev_data_in_q <= data_in;
            valid_q        <= valid_d;
            tc_pulse_q     <= tc_pulse_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    sat_counter #(.WIDTH(WRAP_W)) u_up_wraps (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .inc   (up_wrap),
        .value (up_wraps)
    );

    sat_counter #(.WIDTH(WRAP_W)) u_down_wraps (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .inc   (down_wrap),
        .value (down_wraps)
    );

    assign valid    = valid_q;
    assign tc_pulse = tc_pulse_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
